// File: rtl/shift_normalizer_pkg.sv
// Shared types and constants for the normalizer and the datapath shifter's shift-order encoding.
// Latency: n/a (package).
// Backpressure: n/a (package).
// Contents: shift-type codes, shift-order field positions, FSM state encoding, shift-order builder.
package shift_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    // Shift-type codes as understood by the datapath shifter.
    localparam logic [1:0] SHT_LSL = 2'b00;
    localparam logic [1:0] SHT_LSR = 2'b01;
    localparam logic [1:0] SHT_ASR = 2'b10;
    localparam logic [1:0] SHT_ROR = 2'b11;

    // Shift-order byte layout: [7:3] amount, [2:1] type, [0] register-amount select.
    localparam int SO_AMT_HI  = 7;
    localparam int SO_AMT_LO  = 3;
    localparam int SO_TYPE_HI = 2;
    localparam int SO_TYPE_LO = 1;
    localparam int SO_REG     = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } norm_state_t;

    // Builds an immediate-amount shift order.
    function automatic logic [7:0] make_order(input logic [AMT_W-1:0] amt, input logic [1:0] sht);
        logic [7:0] o;
        o                        = '0;
        o[SO_AMT_HI:SO_AMT_LO]   = amt;
        o[SO_TYPE_HI:SO_TYPE_LO] = sht;
        o[SO_REG]                = 1'b0;
        return o;
    endfunction

endpackage

// File: rtl/shift_normalizer_if.sv
// Request/result bundle between a requester and the shift normalizer.
// Latency: n/a (wires only).
// Backpressure: none; requester watches busy, start is ignored while busy.
// Signals: start/in_data(/dir) toward the normalizer; busy/done/norm_data/shamt/zero/shift_order back.
// Optional: SHIFT_NORM_RIGHT_EN adds the dir request bit.
interface shift_normalizer_if;
    import shift_pkg::*;

    logic              start;
    logic [DATA_W-1:0] in_data;
`ifdef SHIFT_NORM_RIGHT_EN
    logic              dir;
`endif
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] norm_data;
    logic [AMT_W-1:0]  shamt;
    logic              zero;
    logic [7:0]        shift_order;

    modport master (
        output start, in_data,
`ifdef SHIFT_NORM_RIGHT_EN
        output dir,
`endif
        input  busy, done, norm_data, shamt, zero, shift_order
    );

    modport slave (
        input  start, in_data,
`ifdef SHIFT_NORM_RIGHT_EN
        input  dir,
`endif
        output busy, done, norm_data, shamt, zero, shift_order
    );

endinterface

// File: rtl/shift_normalizer_step.sv
// One normalization step: decides whether the work value is finished and how far to shift it next.
// Latency: combinational.
// Backpressure: none.
// Ports: work/dir in; next_work, step_amt (0, 1 or STEP), fin out.
module shift_norm_step
    import shift_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic [DATA_W-1:0] work,
    input  logic              dir,
    output logic [DATA_W-1:0] next_work,
    output logic [AMT_W-1:0]  step_amt,
    output logic              fin
);

    localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

    // Take a full STEP only when it cannot overshoot the first set bit;
    // otherwise fall back to single-bit steps for the remainder.
    always_comb begin
        next_work = work;
        step_amt  = '0;
        fin       = 1'b0;
        if (dir) begin
            if (work[0]) begin
                fin = 1'b1;
            end else if (work[STEP-1:0] == '0) begin
                next_work = work >> STEP;
                step_amt  = STEP_AMT;
            end else begin
                next_work = work >> 1;
                step_amt  = AMT_W'(1);
            end
        end else begin
            if (work[DATA_W-1]) begin
                fin = 1'b1;
            end else if (work[DATA_W-1 -: STEP] == '0) begin
                next_work = work << STEP;
                step_amt  = STEP_AMT;
            end else begin
                next_work = work << 1;
                step_amt  = AMT_W'(1);
            end
        end
    end

endmodule

// File: rtl/shift_normalizer.sv
// Multi-cycle normalizer: shifts a 32-bit operand until its leading (or trailing) bit is set, reports the shift.
// Latency: done at T+2+floor(z/STEP)+(z mod STEP) after start accepted at T; T+1 for a zero operand.
// Backpressure: start only sampled in IDLE; ignored while busy. Results hold until the next done.
// Ports: clk, rst_n (async active-low), bus (slave): start/in_data[/dir] in; busy/done/norm_data/shamt/zero/shift_order out.
// Optional: SHIFT_NORM_RIGHT_EN adds dir; dir=1 strips trailing zeros with a logical right shift.
module shift_normalizer
    import shift_pkg::*;
#(
    parameter int STEP = 1   // 1, 2 or 4
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_normalizer_if.slave bus
);

    norm_state_t       state_q, state_d;
    logic [DATA_W-1:0] work_q;
    logic [AMT_W-1:0]  count_q;
    logic              dir_q;
    logic              dir_in;

    logic [DATA_W-1:0] norm_q;
    logic [AMT_W-1:0]  shamt_q;
    logic              zero_q;
    logic [1:0]        type_q;

    logic [DATA_W-1:0] next_work;
    logic [AMT_W-1:0]  step_amt;
    logic              fin;

`ifdef SHIFT_NORM_RIGHT_EN
    assign dir_in = bus.dir;
`else
    assign dir_in = 1'b0;
`endif

    shift_norm_step #(.STEP(STEP)) u_step (
        .work      (work_q),
        .dir       (dir_q),
        .next_work (next_work),
        .step_amt  (step_amt),
        .fin       (fin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = (bus.in_data == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN:  if (fin) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q  <= '0;
            count_q <= '0;
            dir_q   <= 1'b0;
            norm_q  <= '0;
            shamt_q <= '0;
            zero_q  <= 1'b0;
            type_q  <= SHT_LSL;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.in_data != '0) begin
                            work_q  <= bus.in_data;
                            count_q <= '0;
                            dir_q   <= dir_in;
                        end else begin
                            // Zero operand skips RUN; shift order reads as "no shift".
                            norm_q  <= '0;
                            shamt_q <= '0;
                            zero_q  <= 1'b1;
                            type_q  <= SHT_LSL;
                        end
                    end
                end
                ST_RUN: begin
                    if (fin) begin
                        norm_q  <= work_q;
                        shamt_q <= count_q;
                        zero_q  <= 1'b0;
                        type_q  <= dir_q ? SHT_LSR : SHT_LSL;
                    end else begin
                        // Nonzero operand has at most 31 zeros, so count cannot wrap.
                        work_q  <= next_work;
                        count_q <= count_q + step_amt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.norm_data   = norm_q;
    assign bus.shamt       = shamt_q;
    assign bus.zero        = zero_q;
    assign bus.shift_order = make_order(shamt_q, type_q);

endmodule

// File: tb/tb_shift_normalizer.sv
// Bench: two normalizers (STEP=1 and STEP=4) driven in lockstep; table vectors, corner sequences, random ops.
// Latency: n/a.
// Backpressure: n/a.
module tb_shift_normalizer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] in_data;
    logic        dir;

    int n_checks = 0;
    int n_fail   = 0;

    shift_normalizer_if bus1();
    shift_normalizer_if bus4();

    assign bus1.start   = start;
    assign bus1.in_data = in_data;
    assign bus4.start   = start;
    assign bus4.in_data = in_data;
`ifdef SHIFT_NORM_RIGHT_EN
    assign bus1.dir = dir;
    assign bus4.dir = dir;
`endif

    shift_normalizer #(.STEP(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    shift_normalizer #(.STEP(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    logic [1:0]  done_v, busy_v, zero_v;
    logic [31:0] norm_v  [2];
    logic [4:0]  shamt_v [2];
    logic [7:0]  order_v [2];

    assign done_v   = {bus4.done, bus1.done};
    assign busy_v   = {bus4.busy, bus1.busy};
    assign zero_v   = {bus4.zero, bus1.zero};
    assign norm_v[0]  = bus1.norm_data;
    assign norm_v[1]  = bus4.norm_data;
    assign shamt_v[0] = bus1.shamt;
    assign shamt_v[1] = bus4.shamt;
    assign order_v[0] = bus1.shift_order;
    assign order_v[1] = bus4.shift_order;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        dr;
        logic [31:0] norm;
        logic [4:0]  shamt;
        logic        zero;
        logic [7:0]  order;
        int          lat1;
        int          lat4;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int clz(input logic [31:0] d);
        for (int i = 31; i >= 0; i--) if (d[i]) return 31 - i;
        return 32;
    endfunction

    function automatic int ctz(input logic [31:0] d);
        for (int i = 0; i < 32; i++) if (d[i]) return i;
        return 32;
    endfunction

    // Reference: count the zeros, shift once by that many, latency from the step rule.
    function automatic vec_t model(input logic [31:0] d, input logic dr);
        vec_t v;
        int   z;
        v.data = d;
        v.dr   = dr;
        if (d == 0) begin
            v.norm = 0; v.shamt = 0; v.zero = 1'b1; v.order = 0; v.lat1 = 1; v.lat4 = 1;
        end else begin
            z       = dr ? ctz(d) : clz(d);
            v.norm  = dr ? (d >> z) : (d << z);
            v.shamt = 5'(z);
            v.zero  = 1'b0;
            v.order = 8'(z * 8 + (dr ? 2 : 0));
            v.lat1  = 2 + z;
            v.lat4  = 2 + z / 4 + z % 4;
        end
        return v;
    endfunction

    // What the datapath shifter does with a shift order.
    function automatic logic [31:0] apply_order(input logic [31:0] d, input logic [7:0] o);
        int amt;
        amt = int'(o) / 8;
        case ((int'(o) / 2) % 4)
            0:       return d << amt;
            1:       return d >> amt;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Issue one request to both DUTs and check both; optionally keep start high with junk data
    // during the first RUN cycles (only used with operands long enough to still be busy).
    task automatic run_op(input vec_t v, input bit pester);
        int          lat  [2];
        int          dcnt [2];
        bit          got  [2];
        logic [31:0] cn   [2];
        logic [4:0]  cs   [2];
        logic        cz   [2];
        logic [7:0]  co   [2];
        int          n;
        int          exp_lat;
        string       tag;
        for (int k = 0; k < 2; k++) begin
            lat[k] = 0; dcnt[k] = 0; got[k] = 0; cn[k] = 0; cs[k] = 0; cz[k] = 0; co[k] = 0;
        end
        @(negedge clk);
        start = 1'b1; in_data = v.data; dir = v.dr;
        @(posedge clk); #1;
        if (pester) in_data = ~v.data;
        else        start = 1'b0;
        n = 1;
        while (n <= 60) begin
            for (int k = 0; k < 2; k++) begin
                if (done_v[k]) begin
                    dcnt[k]++;
                    if (!got[k]) begin
                        got[k] = 1; lat[k] = n;
                        cn[k] = norm_v[k]; cs[k] = shamt_v[k]; cz[k] = zero_v[k]; co[k] = order_v[k];
                    end
                end
            end
            if (pester && n == 2) start = 1'b0;
            if (got[0] && got[1] && !busy_v[0] && !busy_v[1]) break;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tag     = $sformatf("d=%08h dir=%0d step=%0d", v.data, v.dr, (k == 0) ? 1 : 4);
            exp_lat = (k == 0) ? v.lat1 : v.lat4;
            chk({"latency ", tag}, 32'(lat[k]), 32'(exp_lat));
            chk({"done_pulses ", tag}, 32'(dcnt[k]), 32'd1);
            chk({"norm_data ", tag}, cn[k], v.norm);
            chk({"shamt ", tag}, 32'(cs[k]), 32'(v.shamt));
            chk({"zero ", tag}, 32'(cz[k]), 32'(v.zero));
            chk({"shift_order ", tag}, 32'(co[k]), 32'(v.order));
            chk({"shifter_replay ", tag}, apply_order(v.data, co[k]), cn[k]);
            chk({"hold ", tag}, norm_v[k], v.norm);
        end
    endtask

    task automatic chk_all_zero(input string name);
        for (int k = 0; k < 2; k++) begin
            chk({name, $sformatf(" busy s%0d", k)}, 32'(busy_v[k]), 32'd0);
            chk({name, $sformatf(" done s%0d", k)}, 32'(done_v[k]), 32'd0);
            chk({name, $sformatf(" norm s%0d", k)}, norm_v[k], 32'd0);
            chk({name, $sformatf(" shamt s%0d", k)}, 32'(shamt_v[k]), 32'd0);
            chk({name, $sformatf(" zero s%0d", k)}, 32'(zero_v[k]), 32'd0);
            chk({name, $sformatf(" order s%0d", k)}, 32'(order_v[k]), 32'd0);
        end
    endtask

    initial begin
        vec_t v;
        int   dones;
        logic [31:0] d;
        logic        dr;

        // data, dir, norm, shamt, zero, order, lat(STEP=1), lat(STEP=4)
        vecs.push_back('{32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0, 8'hF8, 33, 12});
        vecs.push_back('{32'h8000_0000, 1'b0, 32'h8000_0000, 5'd0,  1'b0, 8'h00, 2,  2});
        vecs.push_back('{32'h0000_0000, 1'b0, 32'h0000_0000, 5'd0,  1'b1, 8'h00, 1,  1});
        vecs.push_back('{32'h0000_1234, 1'b0, 32'h91A0_0000, 5'd19, 1'b0, 8'h98, 21, 9});
        vecs.push_back('{32'h0F00_0000, 1'b0, 32'hF000_0000, 5'd4,  1'b0, 8'h20, 6,  3});
        vecs.push_back('{32'h7FFF_FFFF, 1'b0, 32'hFFFF_FFFE, 5'd1,  1'b0, 8'h08, 3,  3});
`ifdef SHIFT_NORM_RIGHT_EN
        vecs.push_back('{32'h0000_0100, 1'b1, 32'h0000_0001, 5'd8,  1'b0, 8'h42, 10, 4});
        vecs.push_back('{32'h8000_0000, 1'b1, 32'h0000_0001, 5'd31, 1'b0, 8'hFA, 33, 12});
        vecs.push_back('{32'h0000_0000, 1'b1, 32'h0000_0000, 5'd0,  1'b1, 8'h00, 1,  1});
`endif

        start = 1'b0; in_data = '0; dir = 1'b0;
        rst_n = 1'b0;
        #12;
        chk_all_zero("reset");
        @(negedge clk); rst_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i], 1'b0);

        // Start held with different data while busy must not disturb the operation.
        run_op(model(32'h0000_0001, 1'b0), 1'b1);
        run_op(model(32'h0000_3000, 1'b0), 1'b1);

        // Async reset in the middle of RUN: no done, outputs cleared, then normal operation.
        @(negedge clk); start = 1'b1; in_data = 32'h0000_0001; dir = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_all_zero("midrun_reset");
        repeat (2) @(posedge clk);
        @(negedge clk); start = 1'b0; rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done_v != 2'b00) dones++;
        end
        chk("midrun_reset no_done", 32'(dones), 32'd0);
        chk_all_zero("after_reset");
        run_op(model(32'h0000_4000, 1'b0), 1'b0);

        for (int r = 0; r < 40; r++) begin
            d = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) d = '0;
`ifdef SHIFT_NORM_RIGHT_EN
            dr = 1'($urandom_range(0, 1));
            if (dr) d = $urandom << $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) d = '0;
`else
            dr = 1'b0;
`endif
            v = model(d, dr);
            run_op(v, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
